// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for the ALU share arbiter: arbiter states, ALUCtr opcodes and the
// single ALU evaluation function used by the top.
package alu_share_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    typedef enum logic [3:0] {
        ALU_ADDU  = 4'h0,
        ALU_SUBU  = 4'h1,
        ALU_AND   = 4'h2,
        ALU_OR    = 4'h3,
        ALU_SLL16 = 4'h4,
        ALU_BGEZ  = 4'h5,
        ALU_XORI  = 4'h6
    } alu_op_e;

    localparam int unsigned ALU_W = 32;

    typedef struct packed {
        logic [ALU_W-1:0] result;
        logic             zero;
    } alu_out_t;

    function automatic alu_out_t alu_eval(input logic [ALU_W-1:0] a,
                                          input logic [ALU_W-1:0] b,
                                          input logic [3:0]       op);
        alu_out_t o;
        case (op)
            ALU_ADDU:  o.result = a + b;
            ALU_SUBU:  o.result = a - b;
            ALU_AND:   o.result = a & b;
            ALU_OR:    o.result = a | b;
            ALU_SLL16: o.result = {b[15:0], 16'h0000};
            // bgez reports "not taken" as 1: set only when A is negative
            ALU_BGEZ:  o.result = {{(ALU_W-1){1'b0}}, a[ALU_W-1]};
            ALU_XORI:  o.result = a ^ b;
            default:   o.result = '0;
        endcase
        o.zero = (o.result == '0);
        return o;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// Combinational round-robin arbiter: one-hot grant over i_req, search starting at
// i_ptr and wrapping modulo N_REQ.
module rr_arbiter #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant
);

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [N_REQ-1:0]   w_first;
    logic [2*N_REQ-1:0] w_back;

    // Rotate so i_ptr sits at bit 0, isolate the lowest set bit, rotate back.
    assign w_dbl   = {i_req, i_req} >> i_ptr;
    assign w_rot   = w_dbl[N_REQ-1:0];
    assign w_first = w_rot & (~w_rot + N_REQ'(1));
    assign w_back  = {{N_REQ{1'b0}}, w_first} << i_ptr;
    assign o_grant = w_back[N_REQ-1:0] | w_back[2*N_REQ-1:N_REQ];

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between N_REQ requesters with round-robin arbitration and a
// registered response held for its owner until consumed.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    input  logic [N_REQ*4-1:0]      req_op,
    output logic [N_REQ-1:0]        rsp_valid,
    input  logic [N_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]       rsp_result,
    output logic                    rsp_zero
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e         r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [N_REQ-1:0]   r_rsp_valid;
    logic [DATA_W-1:0]  r_result;
    logic               r_zero;

    logic [N_REQ-1:0]   w_grant;
    logic               w_owner_rel;
    logic               w_open;
    logic               w_accept;
    logic [DATA_W-1:0]  w_a;
    logic [DATA_W-1:0]  w_b;
    logic [3:0]         w_op;
    logic [PTR_W-1:0]   w_nxt_ptr;
    alu_out_t           w_alu;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant)
    );

    // r_rsp_valid is one-hot on the owner while holding, so it doubles as the owner select.
    assign w_owner_rel = |(rsp_ready & r_rsp_valid);
    assign w_open      = (r_state == ARB_IDLE) || w_owner_rel;
    assign req_ready   = w_grant & {N_REQ{w_open & rst_n}};
    assign w_accept    = |req_ready;

    always_comb begin
        w_a       = '0;
        w_b       = '0;
        w_op      = '0;
        w_nxt_ptr = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_a       = req_a[i*DATA_W +: DATA_W];
                w_b       = req_b[i*DATA_W +: DATA_W];
                w_op      = req_op[i*4 +: 4];
                w_nxt_ptr = PTR_W'((i + 1) % N_REQ);
            end
        end
    end

    assign w_alu = alu_eval(w_a, w_b, w_op);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ARB_IDLE;
            r_ptr       <= '0;
            r_rsp_valid <= '0;
            r_result    <= '0;
            r_zero      <= 1'b0;
        end else if (w_accept) begin
            r_state     <= ARB_HOLD;
            r_ptr       <= w_nxt_ptr;
            r_rsp_valid <= w_grant;
            r_result    <= w_alu.result;
            r_zero      <= w_alu.zero;
        end else if (r_state == ARB_HOLD && w_owner_rel) begin
            r_state     <= ARB_IDLE;
            r_rsp_valid <= '0;
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_result;
    assign rsp_zero   = r_zero;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed, table-driven bench for alu_share_arbiter with N_REQ=2.
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [7:0]  req_op;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;

    int unsigned n_vec;
    int unsigned n_err;

    alu_share_arbiter #(.N_REQ(2), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] a0, b0;
        logic [3:0]  op0;
        logic [31:0] a1, b1;
        logic [3:0]  op1;
        logic [1:0]  rready;
        logic [1:0]  exp_ready;
        logic [1:0]  exp_rv;
        logic [31:0] exp_res;
        logic        exp_zero;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [3:0] op0, input logic [31:0] a1, input logic [31:0] b1,
                         input logic [3:0] op1, input logic [1:0] rr);
        req_valid = v;
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        req_op    = {op1, op0};
        rsp_ready = rr;
    endtask

    // One cycle: drive at negedge, check req_ready before the edge, response after it.
    task automatic step(input vec_t t, input string tag);
        @(negedge clk);
        drive(t.valid, t.a0, t.b0, t.op0, t.a1, t.b1, t.op1, t.rready);
        #1;
        chk({tag, ".req_ready"}, 32'(req_ready), 32'(t.exp_ready));
        @(posedge clk);
        #1;
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(t.exp_rv));
        chk({tag, ".rsp_result"}, rsp_result, t.exp_res);
        chk({tag, ".rsp_zero"}, 32'(rsp_zero), 32'(t.exp_zero));
    endtask

    initial begin
        vec_t h;
        n_vec = 0;
        n_err = 0;

        //            valid  a0            b0            op0   a1            b1            op1   rr     rdy    rv     res           z
        tbl[0]  = '{2'b01, 32'd5,        32'd7,        4'h0, 32'd0,        32'd0,        4'h0, 2'b00, 2'b01, 2'b01, 32'd12,       1'b0};
        tbl[1]  = '{2'b00, 32'd0,        32'd0,        4'h0, 32'd0,        32'd0,        4'h0, 2'b01, 2'b00, 2'b00, 32'd12,       1'b0};
        tbl[2]  = '{2'b10, 32'd0,        32'd0,        4'h0, 32'h1234,     32'h1234,     4'h1, 2'b00, 2'b10, 2'b10, 32'd0,        1'b1};
        tbl[3]  = '{2'b10, 32'd0,        32'd0,        4'h0, 32'hFFFFFFFF, 32'd0,        4'h5, 2'b10, 2'b10, 2'b10, 32'd1,        1'b0};
        tbl[4]  = '{2'b11, 32'hFF00FF00, 32'h0F0F0F0F, 4'h2, 32'h000000F0, 32'h00000F00, 4'h3, 2'b11, 2'b01, 2'b01, 32'h0F000F00, 1'b0};
        tbl[5]  = '{2'b11, 32'hFF00FF00, 32'h0F0F0F0F, 4'h2, 32'h000000F0, 32'h00000F00, 4'h3, 2'b11, 2'b10, 2'b10, 32'h00000FF0, 1'b0};
        tbl[6]  = '{2'b11, 32'hFF00FF00, 32'h0F0F0F0F, 4'h2, 32'h000000F0, 32'h00000F00, 4'h3, 2'b11, 2'b01, 2'b01, 32'h0F000F00, 1'b0};
        tbl[7]  = '{2'b11, 32'h0000FFFF, 32'h00000F0F, 4'h6, 32'h000000F0, 32'h00000F00, 4'h3, 2'b11, 2'b10, 2'b10, 32'h00000FF0, 1'b0};
        tbl[8]  = '{2'b11, 32'h0000FFFF, 32'h00000F0F, 4'h6, 32'h000000F0, 32'h00000F00, 4'h3, 2'b11, 2'b01, 2'b01, 32'h0000F0F0, 1'b0};
        tbl[9]  = '{2'b10, 32'd0,        32'd0,        4'h0, 32'd0,        32'h0000ABCD, 4'h4, 2'b01, 2'b10, 2'b10, 32'hABCD0000, 1'b0};
        tbl[10] = '{2'b01, 32'd123,      32'd456,      4'hF, 32'd0,        32'd0,        4'h0, 2'b10, 2'b01, 2'b01, 32'd0,        1'b1};
        tbl[11] = '{2'b00, 32'd0,        32'd0,        4'h0, 32'd0,        32'd0,        4'h0, 2'b01, 2'b00, 2'b00, 32'd0,        1'b1};

        // Reset with requests already pending: nothing may be accepted.
        rst_n = 1'b0;
        drive(2'b11, 32'd1, 32'd1, 4'h0, 32'd2, 32'd2, 4'h0, 2'b00);
        #3;
        chk("reset.req_ready", 32'(req_ready), 32'd0);
        chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset.rsp_result", rsp_result, 32'd0);
        chk("reset.rsp_zero", 32'(rsp_zero), 32'd0);
        @(negedge clk);
        drive(2'b00, 32'd0, 32'd0, 4'h0, 32'd0, 32'd0, 4'h0, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) step(tbl[i], $sformatf("tbl%0d", i));

        // Stall: req0 accepted, owner withholds rsp_ready for 3 cycles while req1 waits.
        h = '{2'b01, 32'd1, 32'd2, 4'h0, 32'd10, 32'd20, 4'h0, 2'b00, 2'b01, 2'b01, 32'd3, 1'b0};
        step(h, "stall.acc0");
        for (int i = 0; i < 3; i++) begin
            // Non-owner rsp_ready asserted on one cycle; it must be ignored.
            h = '{2'b11, 32'd1, 32'd2, 4'h0, 32'd10, 32'd20, 4'h0, (i == 1) ? 2'b10 : 2'b00,
                  2'b00, 2'b01, 32'd3, 1'b0};
            step(h, $sformatf("stall.hold%0d", i));
        end
        h = '{2'b11, 32'd1, 32'd2, 4'h0, 32'd10, 32'd20, 4'h0, 2'b01, 2'b10, 2'b10, 32'd30, 1'b0};
        step(h, "stall.release");

        // Asynchronous reset mid-HOLD, then req0 wins the tie.
        @(negedge clk);
        drive(2'b11, 32'd100, 32'd200, 4'h0, 32'd7, 32'd8, 4'h0, 2'b00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst.rsp_result", rsp_result, 32'd0);
        chk("arst.rsp_zero", 32'(rsp_zero), 32'd0);
        chk("arst.req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst.tie_ready", 32'(req_ready), 32'b01);
        @(posedge clk);
        #1;
        chk("arst.tie_rsp_valid", 32'(rsp_valid), 32'b01);
        chk("arst.tie_result", rsp_result, 32'd300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
